// File: rtl/bram_word_unpacker_pkg.sv
// Shared constants for the bram18 port-B word unpacker.
// Holds the default bram18 port-B geometry, the pixel geometry and the
// controller state encodings so that the bram18 stage definitions and the
// unpacker agree on one set of numbers.
package bram_word_unpacker_pkg;

   // bram18 port-B geometry (512 x 32)
   localparam int unsigned BWU_ADDR_W       = 9;
   localparam int unsigned BWU_DATA_W       = 32;
   localparam int unsigned BWU_BRAM_DEPTH   = 1 << BWU_ADDR_W;

   // pixel geometry
   localparam int unsigned BWU_PIX_W        = 8;
   localparam int unsigned BWU_PIX_PER_WORD = BWU_DATA_W / BWU_PIX_W;

   // controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/bram_word_unpacker_fifo.sv
// word_fifo2: two-entry word FIFO sitting behind the bram18 read port.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   push_i / wr_data_i    write a word (ignored when full)
//   pop_i                 drop the head word (ignored when empty)
//   rd_data_o             head word
//   full_o, empty_o       occupancy flags
//   count_o               number of stored words, 0..2
module word_fifo2
   import bram_word_unpacker_pkg::*;
#(
   parameter int unsigned DATA_W = BWU_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [1:0]        count_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push_i && (count_q != 2'd2);
   assign do_pop  = pop_i  && (count_q != 2'd0);

   // storage, pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign full_o    = (count_q == 2'd2);
   assign empty_o   = (count_q == 2'd0);
   assign count_o   = count_q;

endmodule

// File: rtl/bram_word_unpacker.sv
// bram_word_unpacker: reads a run of words from a bram18 port B and emits
// them as a valid/ready pixel stream, lane 0 (LSB) first.
// Ports:
//   clkb, rst                       clock, synchronous active-high reset
//   start, base_addr, word_count    segment request, sampled only in IDLE
//   enb, addrb, doutb               bram18 port B (1-cycle read latency)
//   pix_data/pix_valid/pix_ready    pixel stream, pix_last on final pixel
//   busy, done                      segment status; done pulses once
// All outputs except busy are decoded from registered state only; busy also
// reflects a start being accepted in the current cycle.
module bram_word_unpacker
   import bram_word_unpacker_pkg::*;
#(
   parameter int unsigned ADDR_W = BWU_ADDR_W,
   parameter int unsigned DATA_W = BWU_DATA_W,
   parameter int unsigned PIX_W  = BWU_PIX_W
) (
   input  logic              clkb,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              enb,
   output logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] doutb,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PPW    = DATA_W / PIX_W;
   localparam int unsigned LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PPW - 1);

   logic [1:0]        state_q,  state_d;
   logic [ADDR_W-1:0] base_q,   base_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  popped_q, popped_d;
   logic [LANE_W-1:0] lane_q,   lane_d;
   logic              inflight_q;

   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [1:0]        fifo_count;
   logic [2:0]        outstanding;
   logic              xfer;

   // a read issued last cycle always lands in the FIFO this cycle
   word_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_i     (clkb),
      .rst_i     (rst),
      .push_i    (inflight_q),
      .wr_data_i (doutb),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   // state and counters
   always_ff @(posedge clkb) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         cnt_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         lane_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         lane_q     <= lane_d;
         inflight_q <= enb;
      end
   end

   // next state, read issue and pixel decode
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      issued_d  = issued_q;
      popped_d  = popped_q;
      lane_d    = lane_q;
      enb       = 1'b0;
      addrb     = '0;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_last  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      xfer      = 1'b0;
      fifo_pop  = 1'b0;
      // words buffered plus the word (if any) still coming back from the BRAM
      outstanding = {1'b0, fifo_count} + 3'(inflight_q);

      case (state_q)
         ST_IDLE: begin
            busy = start;
            if (start) begin
               base_d   = base_addr;
               cnt_d    = word_count;
               issued_d = '0;
               popped_d = '0;
               lane_d   = '0;
               state_d  = (word_count == '0) ? ST_FLUSH : ST_RUN;
            end
         end

         ST_RUN: begin
            busy = 1'b1;
            if ((issued_q < cnt_q) && (outstanding < 3'd2) && !fifo_full) begin
               enb      = 1'b1;
               addrb    = base_q + ADDR_W'(issued_q);
               issued_d = issued_q + CNT_W'(1);
            end
            if (!fifo_empty) begin
               pix_valid = 1'b1;
               pix_data  = PIX_W'(fifo_head >> (32'(lane_q) * PIX_W));
               // head word index equals the number of words already popped
               pix_last  = (lane_q == LANE_LAST) && (popped_q == cnt_q - CNT_W'(1));
            end
            xfer = pix_valid && pix_ready;
            if (xfer) begin
               if (lane_q == LANE_LAST) begin
                  lane_d   = '0;
                  fifo_pop = 1'b1;
                  popped_d = popped_q + CNT_W'(1);
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
               if (pix_last) begin
                  state_d = ST_FLUSH;
               end
            end
         end

         ST_FLUSH: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bram_word_unpacker.sv
// Self-checking bench for bram_word_unpacker: a 512-word BRAM model with
// 1-cycle read latency, a segment-level reference model (expected pixel
// queue, address sequence, done timing) checked every cycle, plus directed
// segments with hand-computed expectations and randomized segments.
module tb_bram_word_unpacker;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 8;

   logic          clkb = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   word_count;
   logic          enb;
   logic [AW-1:0] addrb;
   logic [DW-1:0] doutb;
   logic [PW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_last;
   logic          busy;
   logic          done;

   bram_word_unpacker #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .PIX_W  (PW)
   ) dut (
      .clkb       (clkb),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .enb        (enb),
      .addrb      (addrb),
      .doutb      (doutb),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_last   (pix_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clkb = ~clkb;

   // BRAM contents and port-B model; junk on doutb when no read was issued
   logic [31:0] mem [512];
   always @(posedge clkb) begin
      if (enb) doutb <= mem[addrb];
      else     doutb <= $urandom;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model state
   bit           m_active = 0;
   int           m_cyc, m_cnt, m_base, m_addr, m_issued, m_xfer;
   logic [7:0]   exp_q[$];
   bit           exp_done = 0;
   bit           no_bubble = 0;
   int           done_cnt = 0;
   int           seen_pix[$];
   int           seen_addr[$];
   int           first_pix_cyc, last_pix_cyc;
   bit           prev_stall = 0;
   logic [7:0]   prev_data;
   logic         prev_last;
   logic [31:0]  mon_w;

   // per-cycle compare against the segment-level model
   always @(negedge clkb) begin : mon
      bit accept_now;
      bit done_next;
      if (rst) begin
         m_active   = 0;
         exp_q.delete();
         exp_done   = 0;
         prev_stall = 0;
      end else begin
         accept_now = start && !m_active;
         done_next  = 0;
         if (m_active) m_cyc++;

         chk(done == exp_done, "done", int'(done), int'(exp_done));
         chk(busy == ((m_active && !exp_done) || accept_now), "busy", int'(busy),
             int'((m_active && !exp_done) || accept_now));
         if (done) done_cnt++;

         if (enb) begin
            chk(m_active && !exp_done, "enb_outside_run", int'(enb), 0);
            chk(addrb == AW'(m_addr), "addrb", int'(addrb), m_addr);
            chk(m_issued < m_cnt, "enb_overissue", m_issued, m_cnt);
            chk((m_issued - m_xfer / 4) < 2, "enb_outstanding", m_issued - m_xfer / 4, 1);
            seen_addr.push_back(int'(addrb));
            m_addr = (m_addr + 1) % 512;
            m_issued++;
         end
         if (m_active && m_cyc == 1 && m_cnt > 0)
            chk(enb == 1'b1, "enb_latency", int'(enb), 1);
         if (m_active && m_cyc == 3 && m_cnt > 0)
            chk(pix_valid == 1'b1, "first_pix_latency", int'(pix_valid), 1);
         if (prev_stall)
            chk(pix_valid && pix_data == prev_data && pix_last == prev_last, "stall_stable",
                int'({pix_valid, pix_last, pix_data}), int'({1'b1, prev_last, prev_data}));
         if (no_bubble && m_active && !exp_done && m_xfer > 0 && exp_q.size() > 0)
            chk(pix_valid == 1'b1, "bubble", int'(pix_valid), 1);

         if (pix_valid) begin
            chk(exp_q.size() > 0, "pix_unexpected", int'(pix_data), 0);
            if (exp_q.size() > 0) begin
               chk(pix_data == exp_q[0], "pix_data", int'(pix_data), int'(exp_q[0]));
               chk(pix_last == (exp_q.size() == 1), "pix_last", int'(pix_last),
                   int'(exp_q.size() == 1));
               chk(m_cyc >= 3, "pix_early", m_cyc, 3);
               if (pix_ready) begin
                  seen_pix.push_back(int'(pix_data));
                  if (m_xfer == 0) first_pix_cyc = m_cyc;
                  m_xfer++;
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) begin
                     done_next    = 1;
                     last_pix_cyc = m_cyc;
                  end
               end
            end
         end
         prev_stall = pix_valid && !pix_ready;
         prev_data  = pix_data;
         prev_last  = pix_last;

         if (exp_done) m_active = 0;
         exp_done = done_next;

         if (accept_now) begin
            m_active = 1;
            m_cyc    = 0;
            m_cnt    = int'(word_count);
            m_base   = int'(base_addr);
            m_addr   = m_base;
            m_issued = 0;
            m_xfer   = 0;
            exp_q.delete();
            for (int i = 0; i < m_cnt; i++) begin
               mon_w = mem[(m_base + i) % 512];
               for (int l = 0; l < 4; l++) exp_q.push_back(8'(mon_w >> (8 * l)));
            end
            if (m_cnt == 0) exp_done = 1;
         end
      end
   end

   // one segment; mode 0: ready high, 1: ready 1-0 toggle, 2: random ready
   task automatic run_seg(input int b, input int c, input int mode, input bit extra);
      int  d0;
      bit  ok;
      d0 = done_cnt;
      ok = 0;
      @(posedge clkb); #1;
      start      = 1'b1;
      base_addr  = AW'(b);
      word_count = (AW + 1)'(c);
      pix_ready  = (mode == 2) ? ($urandom % 4 != 0) : 1'b1;
      for (int k = 0; k < 4000; k++) begin
         @(posedge clkb); #1;
         if (done_cnt != d0) begin
            ok = 1;
            break;
         end
         start      = extra && (k == 1 || k == 3);
         base_addr  = AW'($urandom);
         word_count = (AW + 1)'($urandom);
         case (mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ((k + 1) % 2 == 0);
            default: pix_ready = ($urandom % 4 != 0);
         endcase
      end
      start = 1'b0;
      chk(ok, "done_timeout", done_cnt - d0, 1);
   endtask

   int exp1[8];
   int exp5[4];
   int d0;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      pix_ready  = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      mem[0] = 32'h44332211;
      mem[1] = 32'h88776655;
      exp1 = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88};
      exp5 = '{'h11, 'h22, 'h33, 'h44};

      // reset state
      repeat (3) @(posedge clkb);
      @(negedge clkb);
      chk(enb == 1'b0, "rst_enb", int'(enb), 0);
      chk(addrb == '0, "rst_addrb", int'(addrb), 0);
      chk(pix_valid == 1'b0, "rst_pix_valid", int'(pix_valid), 0);
      chk(pix_last == 1'b0, "rst_pix_last", int'(pix_last), 0);
      chk(pix_data == '0, "rst_pix_data", int'(pix_data), 0);
      chk(busy == 1'b0, "rst_busy", int'(busy), 0);
      chk(done == 1'b0, "rst_done", int'(done), 0);
      @(posedge clkb); #1;
      rst = 1'b0;

      // two preloaded words, full throughput
      seen_pix.delete(); seen_addr.delete();
      no_bubble = 1;
      run_seg(0, 2, 0, 0);
      chk(seen_pix.size() == 8, "t1_count", seen_pix.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < seen_pix.size()) chk(seen_pix[i] == exp1[i], "t1_pix", seen_pix[i], exp1[i]);
      chk(first_pix_cyc == 3, "t1_first_cyc", first_pix_cyc, 3);
      chk(last_pix_cyc == 10, "t1_last_cyc", last_pix_cyc, 10);

      // address wrap
      seen_pix.delete(); seen_addr.delete();
      run_seg(510, 3, 0, 0);
      chk(seen_addr.size() == 3, "t2_nreads", seen_addr.size(), 3);
      if (seen_addr.size() == 3) begin
         chk(seen_addr[0] == 510, "t2_addr0", seen_addr[0], 510);
         chk(seen_addr[1] == 511, "t2_addr1", seen_addr[1], 511);
         chk(seen_addr[2] == 0, "t2_addr2", seen_addr[2], 0);
      end
      chk(seen_pix.size() == 12, "t2_count", seen_pix.size(), 12);

      // back-pressure toggling 1-0
      seen_pix.delete(); seen_addr.delete();
      no_bubble = 0;
      run_seg(100, 4, 1, 0);
      chk(seen_pix.size() == 16, "t3_count", seen_pix.size(), 16);

      // empty segment
      seen_pix.delete(); seen_addr.delete();
      d0 = done_cnt;
      run_seg(7, 0, 0, 0);
      chk(seen_addr.size() == 0, "t4_reads", seen_addr.size(), 0);
      chk(seen_pix.size() == 0, "t4_pix", seen_pix.size(), 0);
      chk(done_cnt - d0 == 1, "t4_done", done_cnt - d0, 1);

      // reset in cycle 5 of an 8-word segment
      @(posedge clkb); #1;
      start = 1'b1; base_addr = '0; word_count = 10'd8; pix_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         @(posedge clkb); #1;
         start = 1'b0;
      end
      @(posedge clkb); #1;
      rst = 1'b1;
      @(posedge clkb); #1;
      rst = 1'b0;
      @(negedge clkb);
      chk(enb == 1'b0, "t5_enb", int'(enb), 0);
      chk(addrb == '0, "t5_addrb", int'(addrb), 0);
      chk(pix_valid == 1'b0, "t5_pix_valid", int'(pix_valid), 0);
      chk(pix_last == 1'b0, "t5_pix_last", int'(pix_last), 0);
      chk(pix_data == '0, "t5_pix_data", int'(pix_data), 0);
      chk(busy == 1'b0, "t5_busy", int'(busy), 0);
      chk(done == 1'b0, "t5_done", int'(done), 0);
      repeat (5) @(posedge clkb);
      seen_pix.delete(); seen_addr.delete();
      run_seg(0, 1, 0, 0);
      chk(seen_pix.size() == 4, "t5_count", seen_pix.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < seen_pix.size()) chk(seen_pix[i] == exp5[i], "t5_pix", seen_pix[i], exp5[i]);

      // start pulses while busy are ignored
      seen_pix.delete(); seen_addr.delete();
      d0 = done_cnt;
      run_seg(20, 3, 2, 1);
      repeat (10) @(posedge clkb);
      chk(done_cnt - d0 == 1, "t6_single_done", done_cnt - d0, 1);
      chk(seen_pix.size() == 12, "t6_count", seen_pix.size(), 12);

      // randomized segments
      for (int s = 0; s < 30; s++) begin
         int b, c, mode;
         b    = int'($urandom % 512);
         c    = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 12));
         mode = int'($urandom % 3);
         no_bubble = (mode == 0);
         seen_pix.delete(); seen_addr.delete();
         run_seg(b, c, mode, (c > 0) && ($urandom % 3 == 0));
         chk(seen_pix.size() == 4 * c, "rnd_count", seen_pix.size(), 4 * c);
      end

      repeat (5) @(posedge clkb);
      @(negedge clkb);
      chk(busy == 1'b0, "final_busy", int'(busy), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
